// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update controller: PC width,
// FIFO entry layout and controller state encoding.
package bp_pkg;
  localparam int PC_W = 10;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
  } bp_update_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} bp_ctrl_state_t;

  // Fetch restart address after a mispredict; not-taken falls through.
  function automatic logic [PC_W-1:0] redirect_of(input logic [PC_W-1:0] pc,
                                                  input logic            taken,
                                                  input logic [PC_W-1:0] target);
    return taken ? target : pc + PC_W'(1);
  endfunction
endpackage

// File: rtl/bp_update_fifo.sv
// Update FIFO between branch resolve and predictor write port.
// Head reads 0 when empty so the predictor never sees stale data.
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [PC_W:0] din,
  output logic          full,
  output logic          empty,
  output logic [PC_W:0] head
);
  localparam int AW = $clog2(DEPTH);

  bp_update_t       mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= bp_update_t'(din);
  end
endmodule

// File: rtl/bp_update_ctrl.sv
// Branch-predictor update controller: queues resolves, drains them to the
// predictor, and flushes on mispredict. Optional statistics: BP_STATS_EN.
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            resolve_valid,
  output logic            resolve_ready,
  input  logic [PC_W-1:0] resolve_pc,
  input  logic            resolve_taken,
  input  logic            resolve_predicted,
  input  logic [PC_W-1:0] resolve_target,
  input  logic            bp_hold,
  output logic            bp_we,
  output logic [PC_W-1:0] bp_update_pc,
  output logic            bp_branch_taken,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     branch_count,
  output logic [15:0]     mispredict_count
);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bp_ctrl_state_t  state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full, empty, accept, push, mispred;
  logic [PC_W:0]   head;
  logic            flush_q;
  logic [PC_W-1:0] redirect_q;

  assign resolve_ready   = !full;
  assign accept          = resolve_valid && !full;
  assign bp_we           = !empty && !bp_hold;
  assign bp_update_pc    = head[PC_W:1];
  assign bp_branch_taken = head[0];
  assign flush           = flush_q;
  assign redirect_pc     = redirect_q;

  bp_update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (bp_we),
    .din   ({resolve_pc, resolve_taken}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FLUSH spans FLUSH_CYCLES cycles starting with the flush-pulse cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: if (mispred) begin
        state_d = FLUSH;
        cnt_d   = CW'(FLUSH_CYCLES - 1);
      end
      FLUSH: if (cnt_q == '0) state_d = RUN;
             else             cnt_d   = cnt_q - CW'(1);
      default: state_d = RUN;
    endcase
  end

  // Wrong-path resolves are still accepted (to unblock execute) but dropped.
  always_comb begin
    push    = accept && (state_q == RUN);
    mispred = push && (resolve_taken != resolve_predicted);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      flush_q    <= mispred;
      redirect_q <= mispred ? redirect_of(resolve_pc, resolve_taken, resolve_target) : '0;
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] br_q, mp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (push && br_q != 16'hFFFF)    br_q <= br_q + 16'd1;
      if (mispred && mp_q != 16'hFFFF) mp_q <= mp_q + 16'd1;
    end
  end

  assign branch_count     = br_q;
  assign mispredict_count = mp_q;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif
endmodule

// File: tb/tb_bp_update_ctrl.sv
// Randomized + directed bench for bp_update_ctrl against a queue-based model.
module tb_bp_update_ctrl;
  localparam int DEPTH = 4;
  localparam int FC    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       resolve_valid, resolve_ready, resolve_taken, resolve_predicted;
  logic [9:0] resolve_pc, resolve_target;
  logic       bp_hold, bp_we, bp_branch_taken, flush;
  logic [9:0] bp_update_pc, redirect_pc;
  logic [15:0] branch_count, mispredict_count;

  bp_update_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .clk               (clk),
    .rst               (rst),
    .resolve_valid     (resolve_valid),
    .resolve_ready     (resolve_ready),
    .resolve_pc        (resolve_pc),
    .resolve_taken     (resolve_taken),
    .resolve_predicted (resolve_predicted),
    .resolve_target    (resolve_target),
    .bp_hold           (bp_hold),
    .bp_we             (bp_we),
    .bp_update_pc      (bp_update_pc),
    .bp_branch_taken   (bp_branch_taken),
    .flush             (flush),
    .redirect_pc       (redirect_pc),
    .branch_count      (branch_count),
    .mispredict_count  (mispredict_count)
  );

  always #5 clk = ~clk;

  // Model: queue of {pc,taken}, remaining flush cycles, last-edge flush info.
  logic [10:0] q[$];
  int          flush_left;
  logic        e_flush;
  logic [9:0]  e_redir;
  int          e_br, e_mp;
  int          n_vec, n_cmp, n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    flush_left = 0;
    e_flush    = 1'b0;
    e_redir    = '0;
    e_br       = 0;
    e_mp       = 0;
  endtask

  task automatic compare_all();
    logic [10:0] h;
    h = (q.size() > 0) ? q[0] : 11'd0;
    chk("resolve_ready",    32'(resolve_ready),    32'(q.size() < DEPTH));
    chk("bp_we",            32'(bp_we),            32'(q.size() > 0 && !bp_hold));
    chk("bp_update_pc",     32'(bp_update_pc),     32'(h[10:1]));
    chk("bp_branch_taken",  32'(bp_branch_taken),  32'(h[0]));
    chk("flush",            32'(flush),            32'(e_flush));
    chk("redirect_pc",      32'(redirect_pc),      32'(e_redir));
    chk("branch_count",     32'(branch_count),     32'(e_br));
    chk("mispredict_count", 32'(mispredict_count), 32'(e_mp));
  endtask

  task automatic model_edge();
    bit acc, in_flush, mp, pop;
    acc      = resolve_valid && (q.size() < DEPTH);
    in_flush = flush_left > 0;
    pop      = (q.size() > 0) && !bp_hold;
    mp       = acc && !in_flush && (resolve_taken != resolve_predicted);
    if (pop) void'(q.pop_front());
    if (acc && !in_flush) begin
      q.push_back({resolve_pc, resolve_taken});
`ifdef BP_STATS_EN
      if (e_br < 65535) e_br++;
      if (mp && e_mp < 65535) e_mp++;
`endif
    end
    if (in_flush) flush_left--;
    if (mp) flush_left = FC;
    e_flush = mp;
    if (!mp)               e_redir = '0;
    else if (resolve_taken) e_redir = resolve_target;
    else                   e_redir = 10'((32'(resolve_pc) + 1) % 1024);
  endtask

  // One cycle: drive at negedge, check settled outputs, advance model, clock.
  task automatic cyc(input logic v, input logic [9:0] pc, input logic t,
                     input logic p, input logic [9:0] tg, input logic h);
    resolve_valid     = v;
    resolve_pc        = pc;
    resolve_taken     = t;
    resolve_predicted = p;
    resolve_target    = tg;
    bp_hold           = h;
    #1;
    compare_all();
    model_edge();
    n_vec++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_cmp = 0; n_fail = 0;
    model_reset();
    rst = 1'b1;
    resolve_valid = 0; resolve_pc = '0; resolve_taken = 0;
    resolve_predicted = 0; resolve_target = '0; bp_hold = 0;
    #1;
    chk("reset ready", 32'(resolve_ready), 32'd1);
    chk("reset bp_we", 32'(bp_we), 32'd0);
    chk("reset flush", 32'(flush), 32'd0);
    chk("reset redirect", 32'(redirect_pc), 32'd0);
    chk("reset counts", 32'({branch_count, mispredict_count}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Correctly predicted taken branch: written next cycle, no flush.
    cyc(1, 10'h010, 1, 1, 10'h000, 0);
    chk("simple bp_we", 32'(bp_we), 32'd1);
    chk("simple pc", 32'(bp_update_pc), 32'h010);
    chk("simple taken", 32'(bp_branch_taken), 32'd1);
    chk("simple flush", 32'(flush), 32'd0);
    idle(2);

    // Not-taken mispredict at top of PC space wraps redirect to 0.
    cyc(1, 10'h3FF, 0, 1, 10'h055, 0);
    chk("wrap flush", 32'(flush), 32'd1);
    chk("wrap redirect", 32'(redirect_pc), 32'h000);
    cyc(1, 10'h100, 1, 1, 10'h000, 0);
    chk("flush one-shot", 32'(flush), 32'd0);
    cyc(1, 10'h101, 1, 1, 10'h000, 0);
    cyc(1, 10'h123, 1, 1, 10'h000, 0);
    chk("third pushed", 32'(bp_update_pc), 32'h123);
    idle(2);

    // Held predictor: FIFO fills after DEPTH, then drains in order.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 10'(32'h40 + i), 1, 1, 10'h000, 1);
      if (i == 3) chk("full ready", 32'(resolve_ready), 32'd0);
    end
    chk("held head", 32'(bp_update_pc), 32'h040);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 10'h000, 0, 0, 10'h000, 0);
      if (i < 3) chk("drain order", 32'(bp_update_pc), 32'(32'h41 + i));
    end
    chk("drained", 32'(bp_we), 32'd0);

    // Mispredict behind two older entries: nothing squashed.
    cyc(1, 10'h011, 0, 0, 10'h000, 1);
    cyc(1, 10'h012, 1, 1, 10'h000, 1);
    cyc(1, 10'h020, 1, 0, 10'h100, 1);
    chk("taken redirect", 32'(redirect_pc), 32'h100);
    chk("older head", 32'(bp_update_pc), 32'h011);
    idle(5);

    // Reset in the middle of FLUSH with three entries pending.
    cyc(1, 10'h031, 1, 1, 10'h000, 1);
    cyc(1, 10'h032, 1, 1, 10'h000, 1);
    cyc(1, 10'h033, 1, 0, 10'h200, 1);
    resolve_valid = 0; bp_hold = 0; rst = 1'b1;
    #1;
    chk("mid rst bp_we", 32'(bp_we), 32'd0);
    chk("mid rst pc", 32'(bp_update_pc), 32'd0);
    chk("mid rst flush", 32'(flush), 32'd0);
    chk("mid rst redirect", 32'(redirect_pc), 32'd0);
    chk("mid rst ready", 32'(resolve_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("post rst bp_we", 32'(bp_we), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic v, t, p, h;
      v = ($urandom_range(0, 99) < 70);
      t = 1'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~t : t;
      h = ($urandom_range(0, 99) < 30);
      cyc(v, 10'($urandom), t, p, 10'($urandom), h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
